cc_bus_ctrl: RTL and testbench

- Coherent memory-bus controller shared by two cores. Each core has one icache and one snooping dcache.
- Arbitrates the single RAM port between 2 icaches and 2 dcaches.
- Sequences snoop transactions (read-miss, write-upgrade) and dirty-block forwarding between dcaches.
- Sits between the per-core caches and the RAM model.

---
 rtl/diaosi_types_pkg.sv | 10 +
 rtl/rr_arb2.sv | 13 +
 rtl/cc_bus_ctrl.sv | 153 +++++++++++++++
 tb/tb_cc_bus_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/diaosi_types_pkg.sv
// Shared types for the dual-core coherent bus controller.
package diaosi_types_pkg;

  localparam int CPUS = 2;

  typedef enum logic [3:0] {
    IDLE, IFETCH, WB1, WB2, SNOOP, UPG, MEM1, MEM2, C2C1, C2C2
  } busctl_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick: on a tie the requester that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o
);

  always_comb begin
    if (req_i == 2'b11) grant_o = ~last_i;
    else                grant_o = req_i[1];
  end

endmodule

// File: rtl/cc_bus_ctrl.sv
// Coherent memory-bus controller: arbitrates one RAM port between two cores'
// icaches and snooping dcaches, and sequences snoops and cache-to-cache forwarding.
module cc_bus_ctrl #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [CPUS-1:0]              iREN,
  input  logic [CPUS-1:0][ADDR_W-1:0]  iaddr,
  output logic [CPUS-1:0]              iwait,
  output logic [CPUS-1:0][31:0]        iload,
  input  logic [CPUS-1:0]              dREN,
  input  logic [CPUS-1:0]              dWEN,
  input  logic [CPUS-1:0][ADDR_W-1:0]  daddr,
  input  logic [CPUS-1:0][31:0]        dstore,
  output logic [CPUS-1:0]              dwait,
  output logic [CPUS-1:0][31:0]        dload,
  input  logic [CPUS-1:0]              cctrans,
  input  logic [CPUS-1:0]              ccwrite,
  output logic [CPUS-1:0]              ccwait,
  output logic [CPUS-1:0]              ccinv,
  output logic [CPUS-1:0][ADDR_W-1:0]  ccsnoopaddr,
  output logic                         ramREN,
  output logic                         ramWEN,
  output logic [ADDR_W-1:0]            ramaddr,
  output logic [31:0]                  ramstore,
  input  logic [31:0]                  ramload,
  input  logic                         ram_ready
);

  import diaosi_types_pkg::*;

  busctl_state_t state_q, state_d;
  logic          req_q, req_d;
  logic          snp_q, snp_d;
  logic          rr_last_q, rr_last_d;

  logic [1:0] wb_req, cc_req;
  logic       wb_g, cc_g, if_g;
  logic       upgrade;

  assign wb_req  = dWEN & ~cctrans;
  assign cc_req  = cctrans & (dREN | ccwrite);
  assign upgrade = ccwrite[req_q] & ~dREN[req_q];

  rr_arb2 u_arb_wb (.req_i(wb_req), .last_i(rr_last_q), .grant_o(wb_g));
  rr_arb2 u_arb_cc (.req_i(cc_req), .last_i(rr_last_q), .grant_o(cc_g));
  rr_arb2 u_arb_if (.req_i(iREN),   .last_i(rr_last_q), .grant_o(if_g));

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      snp_q     <= 1'b1;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      snp_q     <= snp_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    snp_d       = snp_q;
    rr_last_d   = rr_last_q;
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    case (state_q)
      IDLE: begin
        // Class priority WB > CC > IF; round-robin inside each class.
        if (|wb_req) begin
          state_d = WB1;
          req_d   = wb_g;
        end else if (|cc_req) begin
          state_d = SNOOP;
          req_d   = cc_g;
          snp_d   = ~cc_g;
        end else if (|iREN) begin
          state_d = IFETCH;
          req_d   = if_g;
        end
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[req_q];
        if (ram_ready) begin
          iwait[req_q] = 1'b0;
          iload[req_q] = ramload;
          state_d      = IDLE;
        end
      end
      WB1, WB2: begin
        ramWEN       = 1'b1;
        ramaddr      = daddr[req_q];
        ramstore     = dstore[req_q];
        dwait[req_q] = ~ram_ready;
        if (ram_ready) state_d = (state_q == WB1) ? WB2 : IDLE;
      end
      SNOOP: begin
        ccwait[snp_q]      = 1'b1;
        ccsnoopaddr[snp_q] = {daddr[req_q][ADDR_W-1:3], 3'b000};
        ccinv[snp_q]       = ccwrite[req_q];
        if (upgrade)             state_d = UPG;
        else if (ccwrite[snp_q]) state_d = C2C1;
        else                     state_d = MEM1;
      end
      UPG: begin
        ccinv[req_q]  = 1'b1;
        ccwait[snp_q] = 1'b1;
        state_d       = IDLE;
      end
      MEM1, MEM2: begin
        ccinv[req_q] = 1'b1;
        ramREN       = 1'b1;
        ramaddr      = daddr[req_q];
        dload[req_q] = ramload;
        dwait[req_q] = ~ram_ready;
        if (ram_ready) state_d = (state_q == MEM1) ? MEM2 : IDLE;
      end
      C2C1, C2C2: begin
        // Dirty snoopee writes back to RAM while the requester captures the same beat.
        ccinv[req_q] = 1'b1;
        ramWEN       = 1'b1;
        ramaddr      = daddr[snp_q];
        ramstore     = dstore[snp_q];
        dload[req_q] = dstore[snp_q];
        if (ram_ready) begin
          dwait[req_q] = 1'b0;
          dwait[snp_q] = 1'b0;
          state_d      = (state_q == C2C1) ? C2C2 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && state_d == IDLE) rr_last_d = req_q;
  end

endmodule

// File: tb/tb_cc_bus_ctrl.sv
// Directed bench for cc_bus_ctrl: fetch, snooped read-miss, upgrade, cache-to-cache, arbitration, reset abort.
module tb_cc_bus_ctrl;

  logic             CLK;
  logic             nRST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic [1:0]       dREN, dWEN;
  logic [1:0][31:0] daddr, dstore;
  logic [1:0]       dwait;
  logic [1:0][31:0] dload;
  logic [1:0]       cctrans, ccwrite, ccwait, ccinv;
  logic [1:0][31:0] ccsnoopaddr;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic             ram_ready;

  int n_cmp = 0;
  int n_bad = 0;

  cc_bus_ctrl #(.CPUS(2), .ADDR_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then settle just after the edge before driving.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
    cctrans = '0; ccwrite = '0; ramload = '0; ram_ready = 1'b0;
  endtask

  initial begin
    nRST = 1'b0;
    clear_inputs();
    tick();
    tick();
    #1;
    chk("rst_iwait", iwait, 2'b11);
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_ccwait", ccwait, 2'b00);
    chk("rst_ccinv", ccinv, 2'b00);
    chk("rst_ramREN", ramREN, 1'b0);
    chk("rst_ramWEN", ramWEN, 1'b0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_iload0", iload[0], 32'h0);
    chk("rst_dload0", dload[0], 32'h0);
    chk("rst_snpaddr1", ccsnoopaddr[1], 32'h0);

    // Instruction fetch, RAM ready on the third IFETCH cycle
    nRST = 1'b1;
    iREN = 2'b01; iaddr[0] = 32'h100;
    #1 chk("if_idle_ramREN", ramREN, 1'b0);
    tick();
    #1 chk("if_ramREN", ramREN, 1'b1);
    chk("if_ramaddr", ramaddr, 32'h100);
    chk("if_stall_iwait", iwait, 2'b11);
    tick();
    #1 chk("if_stall2_iwait", iwait, 2'b11);
    tick();
    ram_ready = 1'b1; ramload = 32'hDEADBEEF;
    #1 chk("if_done_iwait", iwait, 2'b10);
    chk("if_iload0", iload[0], 32'hDEADBEEF);
    tick();
    clear_inputs();
    #1 chk("if_back_idle", ramREN, 1'b0);

    // Core0 read-miss at 0x240, core1 clean
    cctrans = 2'b01; dREN = 2'b01; daddr[0] = 32'h240;
    tick();
    #1 chk("rm_snp_ccwait", ccwait, 2'b10);
    chk("rm_snp_addr1", ccsnoopaddr[1], 32'h240);
    chk("rm_snp_ccinv", ccinv, 2'b00);
    chk("rm_snp_ramREN", ramREN, 1'b0);
    tick();
    #1 chk("rm_mem1_stall_dwait", dwait, 2'b11);
    chk("rm_mem1_ramREN", ramREN, 1'b1);
    tick();
    ram_ready = 1'b1; ramload = 32'hAAAA0001;
    #1 chk("rm_mem1_addr", ramaddr, 32'h240);
    chk("rm_mem1_ccinv", ccinv, 2'b01);
    chk("rm_mem1_dwait", dwait, 2'b10);
    chk("rm_mem1_dload0", dload[0], 32'hAAAA0001);
    chk("rm_mem1_ccwait", ccwait, 2'b00);
    tick();
    daddr[0] = 32'h244; ramload = 32'hAAAA0002;
    #1 chk("rm_mem2_addr", ramaddr, 32'h244);
    chk("rm_mem2_dload0", dload[0], 32'hAAAA0002);
    chk("rm_mem2_ccinv", ccinv, 2'b01);
    tick();
    clear_inputs();
    #1 chk("rm_back_idle", ramREN, 1'b0);

    // Core1 upgrade at 0x80
    cctrans = 2'b10; ccwrite = 2'b10; daddr[1] = 32'h80;
    tick();
    #1 chk("up_snp_ccwait", ccwait, 2'b01);
    chk("up_snp_ccinv", ccinv, 2'b01);
    chk("up_snp_addr0", ccsnoopaddr[0], 32'h80);
    chk("up_snp_ram", {ramREN, ramWEN}, 2'b00);
    tick();
    #1 chk("up_upg_ccinv", ccinv, 2'b10);
    chk("up_upg_ccwait", ccwait, 2'b01);
    chk("up_upg_dwait", dwait, 2'b11);
    chk("up_upg_ram", {ramREN, ramWEN}, 2'b00);
    tick();
    clear_inputs();
    #1 chk("up_back_idle", ccwait, 2'b00);

    // Core0 read-miss, core1 dirty: cache-to-cache forwarding
    cctrans = 2'b01; dREN = 2'b01; daddr[0] = 32'h240;
    tick();
    cctrans = 2'b11; ccwrite = 2'b10;
    #1 chk("c2c_snp_ccwait", ccwait, 2'b10);
    chk("c2c_snp_ccinv", ccinv, 2'b00);
    tick();
    dWEN = 2'b10; daddr[1] = 32'h240; dstore[1] = 32'h11; ram_ready = 1'b1;
    #1 chk("c2c1_ramWEN", {ramREN, ramWEN}, 2'b01);
    chk("c2c1_ramaddr", ramaddr, 32'h240);
    chk("c2c1_ramstore", ramstore, 32'h11);
    chk("c2c1_dload0", dload[0], 32'h11);
    chk("c2c1_dwait", dwait, 2'b00);
    chk("c2c1_ccinv", ccinv, 2'b01);
    tick();
    daddr[1] = 32'h244; dstore[1] = 32'h22;
    #1 chk("c2c2_ramaddr", ramaddr, 32'h244);
    chk("c2c2_ramstore", ramstore, 32'h22);
    chk("c2c2_dload0", dload[0], 32'h22);
    chk("c2c2_dwait", dwait, 2'b00);
    tick();
    clear_inputs();
    #1 chk("c2c_back_idle", ramWEN, 1'b0);

    // Both WB plus core0 fetch in one cycle; last served was core0
    ram_ready = 1'b1;
    dWEN = 2'b11; daddr[0] = 32'h300; daddr[1] = 32'h400;
    dstore[0] = 32'hA0; dstore[1] = 32'hB0; iREN = 2'b01; iaddr[0] = 32'h500;
    tick();
    #1 chk("arb_wb1_addr", ramaddr, 32'h400);
    chk("arb_wb1_store", ramstore, 32'hB0);
    chk("arb_wb1_dwait", dwait, 2'b01);
    chk("arb_wb1_iwait", iwait, 2'b11);
    tick();
    #1 chk("arb_wb2_addr", ramaddr, 32'h400);
    tick();
    dWEN = 2'b01;
    tick();
    #1 chk("arb_wb0_addr", ramaddr, 32'h300);
    chk("arb_wb0_store", ramstore, 32'hA0);
    chk("arb_wb0_dwait", dwait, 2'b10);
    tick();
    tick();
    dWEN = 2'b00; ramload = 32'h12345678;
    tick();
    #1 chk("arb_if_ramaddr", ramaddr, 32'h500);
    chk("arb_if_ramREN", ramREN, 1'b1);
    chk("arb_if_iwait", iwait, 2'b10);
    chk("arb_if_iload0", iload[0], 32'h12345678);
    tick();
    clear_inputs();

    // Reset while stalled in C2C1
    cctrans = 2'b01; dREN = 2'b01; daddr[0] = 32'h240;
    tick();
    cctrans = 2'b11; ccwrite = 2'b10;
    tick();
    dWEN = 2'b10; daddr[1] = 32'h240; dstore[1] = 32'h33;
    #1 chk("rc_c2c1_ramWEN", ramWEN, 1'b1);
    chk("rc_c2c1_stall_dwait", dwait, 2'b11);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    clear_inputs();
    #1 chk("rc_ramWEN", ramWEN, 1'b0);
    chk("rc_dwait", dwait, 2'b11);
    chk("rc_ccwait", ccwait, 2'b00);
    chk("rc_ramREN", ramREN, 1'b0);

    // After reset rr_last=1, so a fetch tie goes to core0
    iREN = 2'b11; iaddr[0] = 32'h600; iaddr[1] = 32'h700;
    tick();
    #1 chk("rc_tie_ramaddr", ramaddr, 32'h600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
